// File: rtl/param_buf_pkg.sv
// Shared types and default sizes for the ping-pong parameter buffer.
package param_buf_pkg;

  typedef enum logic [1:0] {EMPTY, FILLING, READY, IN_USE} bank_state_t;

  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_DEPTH     = 16;
  localparam int unsigned DEF_NUM_BANKS = 2;

  function automatic logic bank_is_epu(input bank_state_t s);
    return (s == READY) || (s == IN_USE);
  endfunction

endpackage

// File: rtl/param_buf_pingpong_bank.sv
// One single-port parameter bank; the port is granted to the host or the EPU by the bank state.
module param_bank
  import param_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  bank_state_t       state,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  input  logic              epu_cs_i,
  input  logic              epu_oe_i,
  input  logic              epu_we_i,
  input  logic [ADDR_W-1:0] epu_addr_i,
  input  logic [DATA_W-1:0] epu_wdata_i,
  input  logic              rb_re_i,
  input  logic [ADDR_W-1:0] rb_addr_i,
  output logic [DATA_W-1:0] epu_rdata_o,
  output logic [DATA_W-1:0] rb_rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              cs, we, epu_rd, rb_rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    cs     = 1'b0;
    we     = 1'b0;
    epu_rd = 1'b0;
    rb_rd  = 1'b0;
    addr   = '0;
    wdata  = '0;
    unique case (state)
      FILLING: begin
        cs    = host_we_i;
        we    = 1'b1;
        addr  = host_addr_i;
        wdata = host_wdata_i;
      end
      READY, IN_USE: begin
        // EPU always wins the port; readback only uses idle cycles
        if (epu_cs_i) begin
          cs     = 1'b1;
          we     = epu_we_i;
          addr   = epu_addr_i;
          wdata  = epu_wdata_i;
          epu_rd = epu_oe_i & ~epu_we_i;
        end else if (rb_re_i) begin
          cs    = 1'b1;
          addr  = rb_addr_i;
          rb_rd = 1'b1;
        end
      end
      EMPTY: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cs && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      epu_rdata_o <= '0;
      rb_rdata_o  <= '0;
    end else begin
      if (epu_rd) epu_rdata_o <= mem[addr];
      if (rb_rd)  rb_rdata_o  <= mem[addr];
    end
  end

endmodule

// File: rtl/param_buf_pingpong.sv
// Multi-bank parameter buffer: host fills banks in FIFO order while the EPU consumes earlier ones.
// Optional host readback of the last completed bank is enabled by defining PARAM_READBACK_EN.
module param_buf_pingpong
  import param_buf_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
  localparam int unsigned ADDR_W   = $clog2(DEPTH),
  localparam int unsigned BID_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb_i,
  input  logic              host_start_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  input  logic              host_done_i,
  output logic              host_free_o,
  output logic [BID_W-1:0]  host_bank_o,
  output logic              host_err_o,
  input  logic              host_re_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              epu_cs_i,
  input  logic              epu_oe_i,
  input  logic              epu_we_i,
  input  logic [ADDR_W-1:0] epu_addr_i,
  input  logic [DATA_W-1:0] epu_wdata_i,
  output logic [DATA_W-1:0] epu_rdata_o,
  output logic              epu_valid_o,
  output logic [BID_W-1:0]  epu_bank_o,
  input  logic              epu_release_i
);

  function automatic logic [BID_W-1:0] ptr_inc(input logic [BID_W-1:0] p);
    return (p == BID_W'(NUM_BANKS - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [BID_W-1:0] ptr_dec(input logic [BID_W-1:0] p);
    return (p == '0) ? BID_W'(NUM_BANKS - 1) : p - 1'b1;
  endfunction

  bank_state_t st_q [NUM_BANKS];
  bank_state_t st_d [NUM_BANKS];
  logic [BID_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic err_q, err_d;
  logic start_ok, wr_ok, done_ok, rel_ok, epu_act, host_err, rb_err;
  bank_state_t wr_st, rd_st;

  logic [NUM_BANKS-1:0][DATA_W-1:0] bank_epu_rdata, bank_rb_rdata;
  logic [NUM_BANKS-1:0]             bank_rb_re;
  logic [ADDR_W-1:0]                rb_addr;

  assign wr_st       = st_q[wr_ptr_q];
  assign rd_st       = st_q[rd_ptr_q];
  assign host_free_o = (wr_st == EMPTY);
  assign epu_valid_o = bank_is_epu(rd_st);
  assign host_bank_o = wr_ptr_q;
  assign epu_bank_o  = rd_ptr_q;
  assign host_err_o  = err_q;
  assign epu_rdata_o = epu_valid_o ? bank_epu_rdata[rd_ptr_q] : '0;

  assign epu_act  = epu_cs_i & epu_valid_o;
  assign start_ok = enb_i & host_start_i & ~host_done_i & host_free_o;
  assign wr_ok    = enb_i & host_we_i & (wr_st == FILLING);
  assign done_ok  = enb_i & host_done_i & (wr_st == FILLING);
  assign rel_ok   = enb_i & epu_release_i & epu_valid_o;
  // A start alongside done is always rejected, even if the fill closes cleanly
  assign host_err = enb_i & ((host_start_i & (host_done_i | ~host_free_o)) |
                             ((host_we_i | host_done_i) & (wr_st != FILLING)));

  always_comb begin
    st_d     = st_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = host_err | rb_err;
    if (start_ok) st_d[wr_ptr_q] = FILLING;
    if (done_ok) begin
      st_d[wr_ptr_q] = READY;
      wr_ptr_d       = ptr_inc(wr_ptr_q);
    end
    if (epu_act && rd_st == READY) st_d[rd_ptr_q] = IN_USE;
    if (rel_ok) begin
      st_d[rd_ptr_q] = EMPTY;
      rd_ptr_d       = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) st_q[i] <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

`ifdef PARAM_READBACK_EN
  logic              pend_q, rvalid_q, rb_zero_q;
  logic [BID_W-1:0]  pend_bank_q, rb_bank_q, req_bank;
  logic [ADDR_W-1:0] pend_addr_q;
  logic              req, req_ok, conflict, rb_go;

  // A deferred request targets a bank the EPU has since claimed, so IN_USE is still valid
  always_comb begin
    req      = pend_q | host_re_i;
    req_bank = pend_q ? pend_bank_q : ptr_dec(wr_ptr_q);
    rb_addr  = pend_q ? pend_addr_q : host_addr_i;
    req_ok   = pend_q ? bank_is_epu(st_q[req_bank]) : (st_q[req_bank] == READY);
    conflict = epu_act & (rd_ptr_q == req_bank);
    rb_go    = req & req_ok & ~conflict;
    rb_err   = req & ~req_ok;
    for (int i = 0; i < NUM_BANKS; i++) bank_rb_re[i] = rb_go & (req_bank == BID_W'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_bank_q <= '0;
      pend_addr_q <= '0;
      rvalid_q    <= 1'b0;
      rb_zero_q   <= 1'b0;
      rb_bank_q   <= '0;
    end else begin
      pend_q      <= req & req_ok & conflict;
      pend_bank_q <= req_bank;
      pend_addr_q <= rb_addr;
      rvalid_q    <= rb_go | rb_err;
      rb_zero_q   <= rb_err;
      rb_bank_q   <= req_bank;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = (rvalid_q && !rb_zero_q) ? bank_rb_rdata[rb_bank_q] : '0;
`else
  logic unused_rb;
  assign unused_rb  = host_re_i ^ (^bank_rb_rdata);
  assign bank_rb_re = '0;
  assign rb_addr    = '0;
  assign rb_err     = 1'b0;
  assign rvalid_o   = 1'b0;
  assign rdata_o    = '0;
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    param_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk          (clk),
      .rst          (rst),
      .state        (st_q[b]),
      .host_we_i    (wr_ok & (wr_ptr_q == BID_W'(b))),
      .host_addr_i  (host_addr_i),
      .host_wdata_i (host_wdata_i),
      .epu_cs_i     (epu_act & (rd_ptr_q == BID_W'(b))),
      .epu_oe_i     (epu_oe_i),
      .epu_we_i     (epu_we_i),
      .epu_addr_i   (epu_addr_i),
      .epu_wdata_i  (epu_wdata_i),
      .rb_re_i      (bank_rb_re[b]),
      .rb_addr_i    (rb_addr),
      .epu_rdata_o  (bank_epu_rdata[b]),
      .rb_rdata_o   (bank_rb_rdata[b])
    );
  end

endmodule

// File: tb/tb_param_buf_pingpong.sv
// Directed bench for param_buf_pingpong (2 banks x 16 words x 32 bits).
module tb_param_buf_pingpong;

  logic        clk = 1'b0;
  logic        rst, enb;
  logic        host_start, host_we, host_done, host_re;
  logic [3:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_free, host_err, rvalid;
  logic [0:0]  host_bank, epu_bank;
  logic [31:0] rdata, epu_rdata, epu_wdata;
  logic        epu_cs, epu_oe, epu_we, epu_valid, epu_release;
  logic [3:0]  epu_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_buf_pingpong dut (
    .clk           (clk),
    .rst           (rst),
    .enb_i         (enb),
    .host_start_i  (host_start),
    .host_we_i     (host_we),
    .host_addr_i   (host_addr),
    .host_wdata_i  (host_wdata),
    .host_done_i   (host_done),
    .host_free_o   (host_free),
    .host_bank_o   (host_bank),
    .host_err_o    (host_err),
    .host_re_i     (host_re),
    .rvalid_o      (rvalid),
    .rdata_o       (rdata),
    .epu_cs_i      (epu_cs),
    .epu_oe_i      (epu_oe),
    .epu_we_i      (epu_we),
    .epu_addr_i    (epu_addr),
    .epu_wdata_i   (epu_wdata),
    .epu_rdata_o   (epu_rdata),
    .epu_valid_o   (epu_valid),
    .epu_bank_o    (epu_bank),
    .epu_release_i (epu_release)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] base);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      host_we    = 1'b1;
      host_addr  = 4'(i);
      host_wdata = base + 32'(i);
      tick();
    end
    host_we   = 1'b0;
    host_done = 1'b1;
    tick();
    host_done = 1'b0;
  endtask

  task automatic epu_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
    epu_cs   = 1'b1;
    epu_oe   = 1'b1;
    epu_addr = a;
    tick();
    epu_cs = 1'b0;
    epu_oe = 1'b0;
    chk(tag, epu_rdata, exp);
  endtask

  task automatic release_bank();
    epu_release = 1'b1;
    tick();
    epu_release = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enb = 1'b1;
    host_start = 1'b0; host_we = 1'b0; host_done = 1'b0; host_re = 1'b0;
    host_addr = '0; host_wdata = '0;
    epu_cs = 1'b0; epu_oe = 1'b0; epu_we = 1'b0; epu_addr = '0; epu_wdata = '0;
    epu_release = 1'b0;
    tick();
    tick();

    // 1. reset values, first fill and EPU read
    chk("rst_free", host_free, 1);
    chk("rst_valid", epu_valid, 0);
    chk("rst_hbank", host_bank, 0);
    chk("rst_ebank", epu_bank, 0);
    chk("rst_err", host_err, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_erdata", epu_rdata, 0);
    rst = 1'b0;
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("open_free", host_free, 0);
    for (int i = 0; i < 16; i++) begin
      host_we = 1'b1; host_addr = 4'(i); host_wdata = 32'hA0 + 32'(i);
      tick();
    end
    host_we = 1'b0; host_done = 1'b1;
    tick();
    host_done = 1'b0;
    chk("t1_valid", epu_valid, 1);
    chk("t1_hbank", host_bank, 1);
    chk("t1_free", host_free, 1);
    chk("t1_err", host_err, 0);
    epu_read(4'd5, 32'hA5, "t1_rd5");
    tick();
    chk("t1_hold", epu_rdata, 32'hA5);

    // 2. EPU reads bank0 while host fills bank1
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      host_we = 1'b1; host_addr = 4'(i); host_wdata = 32'hB0 + 32'(i);
      epu_cs = 1'b1; epu_oe = 1'b1; epu_addr = 4'(i);
      tick();
      chk("t2_overlap", epu_rdata, 32'hA0 + 32'(i));
    end
    host_we = 1'b0; epu_cs = 1'b0; epu_oe = 1'b0;
    host_done = 1'b1;
    tick();
    host_done = 1'b0;
    chk("t2_hbank_wrap", host_bank, 0);
    chk("t2_full", host_free, 0);
    release_bank();
    chk("t2_ebank", epu_bank, 1);
    chk("t2_valid", epu_valid, 1);
    chk("t2_free", host_free, 1);
    epu_read(4'd3, 32'hB3, "t2_rd3");

    // 3. full buffer, rejected start and write
    release_bank();
    chk("t3_empty_valid", epu_valid, 0);
    chk("t3_empty_rdata", epu_rdata, 0);
    chk("t3_ebank", epu_bank, 0);
    fill(32'h10);
    fill(32'h20);
    chk("t3_full", host_free, 0);
    chk("t3_valid", epu_valid, 1);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("t3_start_err", host_err, 1);
    chk("t3_start_free", host_free, 0);
    chk("t3_start_hbank", host_bank, 0);
    tick();
    chk("t3_err_pulse", host_err, 0);
    host_we = 1'b1; host_addr = 4'd2; host_wdata = 32'hFFFF;
    tick();
    host_we = 1'b0;
    chk("t3_we_err", host_err, 1);
    epu_read(4'd2, 32'h12, "t3_nocorrupt");

    // 4. done and release in the same cycle
    release_bank();
    release_bank();
    chk("t4_drained", epu_valid, 0);
    fill(32'h30);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    host_we = 1'b1; host_addr = 4'd0; host_wdata = 32'h40;
    tick();
    host_we = 1'b0;
    host_done = 1'b1; epu_release = 1'b1;
    tick();
    host_done = 1'b0; epu_release = 1'b0;
    chk("t4_hbank", host_bank, 0);
    chk("t4_ebank", epu_bank, 1);
    chk("t4_free", host_free, 1);
    chk("t4_valid", epu_valid, 1);
    chk("t4_err", host_err, 0);
    epu_read(4'd0, 32'h40, "t4_rd0");

    // 5. reset mid-fill, then enable gating
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      host_we = 1'b1; host_addr = 4'(i); host_wdata = 32'h50 + 32'(i);
      tick();
    end
    host_addr = 4'd7; host_wdata = 32'h57; rst = 1'b1;
    tick();
    rst = 1'b0; host_we = 1'b0;
    chk("t5_free", host_free, 1);
    chk("t5_valid", epu_valid, 0);
    chk("t5_hbank", host_bank, 0);
    chk("t5_ebank", epu_bank, 0);
    chk("t5_err", host_err, 0);
    chk("t5_erdata", epu_rdata, 0);
    enb = 1'b0; host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("t5_enb_start", host_free, 1);
    chk("t5_enb_err", host_err, 0);
    enb = 1'b1; host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("t5_open", host_free, 0);
    enb = 1'b0; host_we = 1'b1; host_addr = 4'd1; host_wdata = 32'hDEAD;
    tick();
    host_we = 1'b0; host_done = 1'b1;
    tick();
    host_done = 1'b0;
    chk("t5_enb_done", epu_valid, 0);
    enb = 1'b1; host_done = 1'b1;
    tick();
    host_done = 1'b0;
    chk("t5_done", epu_valid, 1);
    epu_read(4'd1, 32'h51, "t5_enb_we_dropped");

    // 6. host readback of the last completed bank
    release_bank();
    fill(32'hC0);
    chk("t6_valid", epu_valid, 1);
    chk("t6_ebank", epu_bank, 1);
    host_re = 1'b1; host_addr = 4'd9;
    tick();
    host_re = 1'b0;
`ifdef PARAM_READBACK_EN
    chk("t6_rvalid", rvalid, 1);
    chk("t6_rdata", rdata, 32'hC9);
    chk("t6_err", host_err, 0);
    tick();
    chk("t6_rvalid_pulse", rvalid, 0);
    chk("t6_rdata_idle", rdata, 0);
    host_re = 1'b1; host_addr = 4'd4;
    epu_cs = 1'b1; epu_oe = 1'b1; epu_addr = 4'd9;
    tick();
    host_re = 1'b0; epu_cs = 1'b0; epu_oe = 1'b0;
    chk("t6_epu_first", epu_rdata, 32'hC9);
    chk("t6_deferred", rvalid, 0);
    tick();
    chk("t6_retry_valid", rvalid, 1);
    chk("t6_retry_data", rdata, 32'hC4);
    release_bank();
    host_re = 1'b1; host_addr = 4'd9;
    tick();
    host_re = 1'b0;
    chk("t6_bad_rvalid", rvalid, 1);
    chk("t6_bad_rdata", rdata, 0);
    chk("t6_bad_err", host_err, 1);
`else
    chk("t6_no_rvalid", rvalid, 0);
    chk("t6_no_rdata", rdata, 0);
    chk("t6_no_err", host_err, 0);
    epu_read(4'd9, 32'hC9, "t6_rd9");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
